alu_accum_ctrl: RTL and testbench
=================================

Name: alu_accum_ctrl

Overview:
Sequential command front-end and result stage for the team's combinational 8-bit ALU (6 ops: ADD, SUB, AND, OR, XOR, NOT A). It accepts operation commands over a valid/ready handshake and drives the ALU operands and select, with the accumulator always on A. It captures the ALU result and carry back into the accumulator, updates status flags and returns a handshaked response. It sits directly upstream and downstream of the ALU instance.

Parameters:
WIDTH, 8, datapath width; matches ALU A/B/result width.
CNT_W, 16, width of completed-operation counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 LOAD, 111 illegal.
cmd_data  input  WIDTH  operand B; load value for LOAD.
alu_a  output  WIDTH  to ALU A; always equals acc.
alu_b  output  WIDTH  to ALU B; latched cmd_data.
alu_sel  output  3  to ALU sel; latched cmd_op.
alu_result  input  WIDTH  from ALU result.
alu_carry  input  1  from ALU carry_out.
rsp_valid  output  1  response/result available.
rsp_ready  input  1  consumer accepts response.
rsp_err  output  1  qualifies rsp_valid; illegal op.
acc  output  WIDTH  accumulator.
flag_z  output  1  acc == 0 after last legal op.
flag_c  output  1  carry from last ADD/SUB.
flag_n  output  1  acc MSB after last legal op.
op_count  output  CNT_W  count of completed (responded) commands.

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc, alu_b, alu_sel, flags, rsp_err, op_count = 0; rsp_valid=0; cmd_ready=1 after release. Reset mid-operation drops the in-flight command; no response is issued.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1, rsp_valid=0. On cmd_valid&cmd_ready at edge k: latch cmd_data into alu_b and cmd_op into alu_sel, then go to EXEC.
- EXEC is one cycle; cmd_ready=0. The ALU settles combinationally on alu_a/alu_b/alu_sel. At the end of the cycle:
  - op 000-101: acc <= alu_result; flag_z = (alu_result==0); flag_n = alu_result[WIDTH-1]; flag_c = alu_carry for 000/001, 0 for 010-101; rsp_err <= 0.
  - op 110 LOAD: acc <= alu_b; flag_z and flag_n from the loaded value; flag_c = 0; rsp_err <= 0. The ALU output is ignored.
  - op 111: acc and flags unchanged; rsp_err <= 1.
  - Then go to RESP.
- RESP: rsp_valid=1, cmd_ready=0. acc, flags and rsp_err are held stable. On rsp_ready: op_count increments, wrapping at 2^CNT_W-1 to 0. The FSM then returns to IDLE, and rsp_valid drops the next cycle.
- Latency: command accepted at edge k; acc updated at edge k+1; rsp_valid high from edge k+1 to the edge where rsp_ready is seen.
- Throughput: max one command per 3 cycles. No command is accepted while in EXEC or RESP; cmd_valid there is ignored, and the upstream must hold it.
- rsp_ready outside RESP has no effect. rsp_valid never deasserts without rsp_ready, except on reset.
- alu_a = acc at all times. alu_b and alu_sel hold their last values outside EXEC.
- Arithmetic is modulo 2^WIDTH; the carry semantics for SUB are exactly those of the ALU's carry_out.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC → acc=0, flags=0, rsp_valid=0, op_count=0; after release cmd_ready=1, state IDLE.
- LOAD 0x0F, then ADD 0x01 → acc=0x10, z=0, c=0, n=0; rsp_valid rises one edge after accept; op_count=2.
- LOAD 0xFF, then ADD 0x01 → acc=0x00, z=1, c=1, n=0; then SUB 0x02 → acc=0xFE, n=1, c=ALU carry_out value.
- LOAD 0xAA, AND 0xCC → acc=0x88, n=1, c=0; OR 0x33 → 0xBB; XOR 0xFF → 0x44; NOT → 0xBB.
- Backpressure: hold rsp_ready=0 for 4 cycles with cmd_valid=1 → rsp_valid, acc and flags stable; cmd_ready=0; the second command is accepted only after the response handshake.
- Illegal op 111 with acc=0x55 → rsp_err=1, acc=0x55, flags unchanged, op_count increments; the next legal op returns rsp_err=0.

Source files
------------

// File: rtl/alu_accum_ctrl_if.sv
// Handshake and ALU-side bundle for alu_accum_ctrl: command in, response out,
// and the operand/result wires to the combinational ALU.
interface alu_accum_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_err;

  // Environment side: issues commands, consumes responses, hosts the ALU.
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, alu_result, alu_carry,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, alu_result, alu_carry,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_err
  );
endinterface

// File: rtl/alu_accum_ctrl.sv
// Command front-end and result stage wrapped around the 8-bit combinational ALU.
// Accumulator feeds ALU A; each accepted command runs IDLE -> EXEC -> RESP.
module alu_accum_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_accum_ctrl_if.slave     bus,
  output logic [WIDTH-1:0]    acc,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_n,
  output logic [CNT_W-1:0]    op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_LOAD = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  state_e           state;
  op_e              sel_q;
  logic [WIDTH-1:0] b_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;

  assign bus.alu_a     = acc;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

  // NOTE: every register, handshake outputs included, is assigned with <= in this
  // one clocked block so all of them see pre-edge values; blocking here would
  // let later statements observe half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= OP_ADD;
      b_q         <= '0;
      acc         <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_n      <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count    <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            b_q         <= bus.cmd_data;
            sel_q       <= op_e'(bus.cmd_op);
            cmd_ready_q <= 1'b0;
            state       <= EXEC;
          end
        end

        EXEC: begin
          case (sel_q)
            OP_ADD, OP_SUB: begin
              acc       <= bus.alu_result;
              flag_z    <= (bus.alu_result == '0);
              flag_n    <= bus.alu_result[WIDTH-1];
              flag_c    <= bus.alu_carry;
              rsp_err_q <= 1'b0;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              acc       <= bus.alu_result;
              flag_z    <= (bus.alu_result == '0);
              flag_n    <= bus.alu_result[WIDTH-1];
              flag_c    <= 1'b0;
              rsp_err_q <= 1'b0;
            end
            // LOAD bypasses the ALU entirely; its output is whatever sel 110 gives.
            OP_LOAD: begin
              acc       <= b_q;
              flag_z    <= (b_q == '0);
              flag_n    <= b_q[WIDTH-1];
              flag_c    <= 1'b0;
              rsp_err_q <= 1'b0;
            end
            default: begin
              rsp_err_q <= 1'b1;
            end
          endcase
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            op_count    <= op_count + CNT_W'(1);
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// Directed bench for alu_accum_ctrl with a behavioural ALU closing the loop.
// Expected values are hand-computed per vector.
module tb_alu_accum_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] AND_ = 3'b010;
  localparam logic [2:0] OR_  = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100;
  localparam logic [2:0] NOT_ = 3'b101;
  localparam logic [2:0] LOAD = 3'b110;
  localparam logic [2:0] ILL  = 3'b111;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] acc;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  alu_accum_ctrl_if #(.WIDTH(WIDTH)) if_i ();

  alu_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if_i),
    .acc      (acc),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_n   (flag_n),
    .op_count (op_count)
  );

  // ALU model; SUB carry_out is the borrow bit of a 9-bit subtract. Non-arith ops
  // drive carry=1 and sel 110/111 drive junk so misuse of them shows up.
  always_comb begin
    if_i.alu_result = 8'hA5;
    if_i.alu_carry  = 1'b1;
    case (if_i.alu_sel)
      ADD:  {if_i.alu_carry, if_i.alu_result} = {1'b0, if_i.alu_a} + {1'b0, if_i.alu_b};
      SUB:  {if_i.alu_carry, if_i.alu_result} = {1'b0, if_i.alu_a} - {1'b0, if_i.alu_b};
      AND_: if_i.alu_result = if_i.alu_a & if_i.alu_b;
      OR_:  if_i.alu_result = if_i.alu_a | if_i.alu_b;
      XOR_: if_i.alu_result = if_i.alu_a ^ if_i.alu_b;
      NOT_: if_i.alu_result = ~if_i.alu_a;
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one command, and checks the
  // EXEC cycle and the rise of rsp_valid one edge after acceptance.
  task automatic start_cmd(input logic [2:0] op, input logic [7:0] data);
    int n = 0;
    while (if_i.cmd_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(if_i.cmd_ready), 32'd1);
    if_i.cmd_valid = 1'b1;
    if_i.cmd_op    = op;
    if_i.cmd_data  = data;
    tick();
    if_i.cmd_valid = 1'b0;
    check("exec_cmd_ready", 32'(if_i.cmd_ready), 32'd0);
    check("exec_rsp_valid", 32'(if_i.rsp_valid), 32'd0);
    tick();
    check("rsp_valid_rise", 32'(if_i.rsp_valid), 32'd1);
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] e_acc, input logic e_z,
                           input logic e_c, input logic e_n, input logic e_err);
    check({tag, "_acc"},   32'(acc),          32'(e_acc));
    check({tag, "_alu_a"}, 32'(if_i.alu_a),   32'(e_acc));
    check({tag, "_z"},     32'(flag_z),       32'(e_z));
    check({tag, "_c"},     32'(flag_c),       32'(e_c));
    check({tag, "_n"},     32'(flag_n),       32'(e_n));
    check({tag, "_err"},   32'(if_i.rsp_err), 32'(e_err));
  endtask

  task automatic end_rsp();
    if_i.rsp_ready = 1'b1;
    tick();
    if_i.rsp_ready = 1'b0;
    exp_cnt++;
    check("rsp_valid_drop", 32'(if_i.rsp_valid), 32'd0);
    check("op_count",       32'(op_count),       32'(exp_cnt));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] data,
                        input logic [7:0] e_acc, input logic e_z, input logic e_c,
                        input logic e_n, input logic e_err);
    start_cmd(op, data);
    check_rsp(tag, e_acc, e_z, e_c, e_n, e_err);
    end_rsp();
  endtask

  initial begin
    rst_n          = 1'b1;
    if_i.cmd_valid = 1'b0;
    if_i.cmd_op    = 3'b000;
    if_i.cmd_data  = 8'h00;
    if_i.rsp_ready = 1'b0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_acc",       32'(acc),            32'd0);
    check("rst_rsp_valid", 32'(if_i.rsp_valid), 32'd0);
    check("rst_op_count",  32'(op_count),       32'd0);
    check("rst_alu_b",     32'(if_i.alu_b),     32'd0);
    check("rst_alu_sel",   32'(if_i.alu_sel),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rel_cmd_ready", 32'(if_i.cmd_ready), 32'd1);

    // Basic add and the stated latency.
    run_op("ld0f",  LOAD, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add01", ADD,  8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Carry/zero on wrap, then SUB borrow.
    run_op("ldff",  LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("addwr", ADD,  8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub02", SUB,  8'h02, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);

    // Logic ops clear carry.
    run_op("ldaa",  LOAD, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("andcc", AND_, 8'hCC, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("or33",  OR_,  8'h33, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("xorff", XOR_, 8'hFF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("not",   NOT_, 8'h00, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_z", SUB,  8'hBB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // rsp_ready outside RESP has no effect.
    if_i.rsp_ready = 1'b1;
    tick();
    tick();
    if_i.rsp_ready = 1'b0;
    check("idle_rdy_cnt",   32'(op_count),       32'(exp_cnt));
    check("idle_rdy_valid", 32'(if_i.rsp_valid), 32'd0);

    // Backpressure with a second command held pending.
    start_cmd(LOAD, 8'h55);
    if_i.cmd_valid = 1'b1;
    if_i.cmd_op    = ADD;
    if_i.cmd_data  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_cmd_ready", 32'(if_i.cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(if_i.rsp_valid), 32'd1);
      check_rsp("bp", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    end_rsp();
    check("bp_idle_ready", 32'(if_i.cmd_ready), 32'd1);
    check("bp_idle_acc",   32'(acc),            32'h55);
    tick();
    if_i.cmd_valid = 1'b0;
    check("bp_accepted", 32'(if_i.cmd_ready), 32'd0);
    tick();
    check("bp2_rsp_valid", 32'(if_i.rsp_valid), 32'd1);
    check_rsp("bp2", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    end_rsp();

    // Illegal op leaves acc and flags (carry set) untouched.
    run_op("ldff2", LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("add56", ADD,  8'h56, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ill",   ILL,  8'h12, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("postil", XOR_, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-EXEC drops the command.
    run_op("ld7e", LOAD, 8'h7E, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    if_i.cmd_valid = 1'b1;
    if_i.cmd_op    = ADD;
    if_i.cmd_data  = 8'h90;
    tick();
    if_i.cmd_valid = 1'b0;
    check("pre_rst_exec", 32'(if_i.cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc",   32'(acc),            32'd0);
    check("mid_rst_z",     32'(flag_z),         32'd0);
    check("mid_rst_c",     32'(flag_c),         32'd0);
    check("mid_rst_n",     32'(flag_n),         32'd0);
    check("mid_rst_valid", 32'(if_i.rsp_valid), 32'd0);
    check("mid_rst_cnt",   32'(op_count),       32'd0);
    exp_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(if_i.cmd_ready), 32'd1);
    tick();
    check("post_rst_valid", 32'(if_i.rsp_valid), 32'd0);
    check("post_rst_acc",   32'(acc),            32'd0);

    run_op("r_ld0f",  LOAD, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("r_add01", ADD,  8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("final_count", 32'(op_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop should the sequence ever stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
